sobel_window_feeder: RTL and testbench

- Producer end of the sobel_edge_detector input handshake.
- Walks a stored image in 4x4 windows: column stride 2, row stride 2.
- Reads pixels from a single-port image memory and presents each window on input_pixels with a one-cycle bus_data_ready pulse whenever the detector raises need_data.
- Reuses overlapping columns, so only 8 new pixels are fetched per horizontal step.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_window_addr_gen.sv | 69 ++++++
 rtl/sobel_window_feeder.sv | 128 ++++++++++++
 tb/tb_sobel_window_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the sobel window feeder.
package sobel_pkg;

  localparam int unsigned PIX_W      = 4;
  localparam int unsigned WIN_SIZE   = 4;
  localparam int unsigned WIN_STRIDE = 2;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef pixel_t [3:0][3:0] window_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_READY,
    ST_HANDOFF,
    ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/sobel_window_addr_gen.sv
// Window position (r, c) and in-window fetch position (i, j) counters.
module sobel_window_addr_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 400,
  parameter int unsigned IMG_HEIGHT = 300,
  parameter int unsigned ADDR_BITS  = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 adv_pixel,
  input  logic                 adv_window,
  output logic [1:0]           pix_i,
  output logic [1:0]           pix_j,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 last_pixel,
  output logic                 last_window
);

  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - WIN_SIZE);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - WIN_SIZE);
  localparam logic [1:0]    J_HALF = 2'(WIN_STRIDE);

  logic [RW-1:0] r;
  logic [CW-1:0] c;

  // Steps need only the two new columns once c > 0, so j restarts at the stride.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      c     <= '0;
      pix_i <= '0;
      pix_j <= '0;
    end else if (init) begin
      r     <= '0;
      c     <= '0;
      pix_i <= '0;
      pix_j <= '0;
    end else if (adv_window) begin
      pix_i <= '0;
      if (c < C_LAST) begin
        c     <= c + CW'(WIN_STRIDE);
        pix_j <= J_HALF;
      end else begin
        c     <= '0;
        r     <= r + RW'(WIN_STRIDE);
        pix_j <= '0;
      end
    end else if (adv_pixel) begin
      if (pix_j == 2'd3) begin
        pix_i <= pix_i + 2'd1;
        pix_j <= (c == '0) ? 2'd0 : J_HALF;
      end else begin
        pix_j <= pix_j + 2'd1;
      end
    end
  end

  always_comb begin
    addr = (ADDR_BITS'(r) + ADDR_BITS'(pix_i)) * ADDR_BITS'(IMG_WIDTH)
         + ADDR_BITS'(c) + ADDR_BITS'(pix_j);
    last_pixel  = (pix_i == 2'd3) && (pix_j == 2'd3);
    last_window = (r == R_LAST) && (c == C_LAST);
  end

endmodule

// File: rtl/sobel_window_feeder.sv
// Streams 4x4 stride-2 windows from image memory to the sobel detector.
module sobel_window_feeder
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 400,
  parameter int unsigned IMG_HEIGHT = 300,
  parameter int unsigned PIXEL_BITS = 4,
  parameter int unsigned ADDR_BITS  = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             need_data,
  output logic                             bus_data_ready,
  output logic [3:0][3:0][PIXEL_BITS-1:0]  input_pixels,
  output logic [ADDR_BITS-1:0]             mem_addr,
  output logic                             mem_read,
  input  logic [PIXEL_BITS-1:0]            mem_rdata,
  input  logic                             mem_valid,
  output logic                             busy,
  output logic                             done
);

  feeder_state_t                   state;
  logic [3:0][3:0][PIXEL_BITS-1:0] work;
  logic                            req_pending;

  logic                 gen_init;
  logic                 gen_adv_pixel;
  logic                 gen_adv_window;
  logic [1:0]           pix_i;
  logic [1:0]           pix_j;
  logic [ADDR_BITS-1:0] gen_addr;
  logic                 last_pixel;
  logic                 last_window;

  sobel_window_addr_gen #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .init       (gen_init),
    .adv_pixel  (gen_adv_pixel),
    .adv_window (gen_adv_window),
    .pix_i      (pix_i),
    .pix_j      (pix_j),
    .addr       (gen_addr),
    .last_pixel (last_pixel),
    .last_window(last_window)
  );

  // Counter strobes follow the FSM state directly.
  always_comb begin
    gen_init       = (state == ST_IDLE) && start;
    gen_adv_pixel  = (state == ST_WAIT_RD) && mem_valid;
    gen_adv_window = (state == ST_HANDOFF);
  end

  // A need_data seen while fetching is latched so it is served once on READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      bus_data_ready <= 1'b0;
      mem_read       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      input_pixels   <= '0;
      mem_addr       <= '0;
      work           <= '0;
      req_pending    <= 1'b0;
    end else begin
      bus_data_ready <= 1'b0;
      mem_read       <= 1'b0;
      done           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            req_pending <= 1'b0;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          mem_read <= 1'b1;
          mem_addr <= gen_addr;
          if (need_data) req_pending <= 1'b1;
          state    <= ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (need_data) req_pending <= 1'b1;
          if (mem_valid) begin
            work[pix_i][pix_j] <= mem_rdata;
            state <= last_pixel ? ST_READY : ST_FETCH;
          end
        end
        ST_READY: begin
          if (need_data || req_pending) begin
            input_pixels   <= work;
            bus_data_ready <= 1'b1;
            req_pending    <= 1'b0;
            state          <= ST_HANDOFF;
          end
        end
        ST_HANDOFF: begin
          // Overlap reuse: right half slides left; it is fully rewritten on a row wrap.
          for (int unsigned k = 0; k < WIN_SIZE; k++) begin
            work[k][0] <= work[k][2];
            work[k][1] <= work[k][3];
          end
          if (last_window) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder on an 8x6 image.
module tb_sobel_window_feeder;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned PB = 4;
  localparam int unsigned AB = $clog2(W*H);
  localparam int unsigned NWIN = 6;

  typedef logic [3:0][3:0][PB-1:0] win_t;
  typedef struct { int unsigned tag; int unsigned addr; } rd_t;
  typedef struct { int unsigned r; int unsigned c; int unsigned nrd; int unsigned first; int unsigned last; } vec_t;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          start;
  logic          need_data;
  logic          bus_data_ready;
  win_t          input_pixels;
  logic [AB-1:0] mem_addr;
  logic          mem_read;
  logic [PB-1:0] mem_rdata;
  logic          mem_valid;
  logic          busy;
  logic          done;

  always #5 tb_clk = ~tb_clk;

  sobel_window_feeder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIXEL_BITS(PB)
  ) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .start         (start),
    .need_data     (need_data),
    .bus_data_ready(bus_data_ready),
    .input_pixels  (input_pixels),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_rdata     (mem_rdata),
    .mem_valid     (mem_valid),
    .busy          (busy),
    .done          (done)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  function automatic logic [PB-1:0] pix_of(input logic [AB-1:0] a);
    int unsigned x;
    x = 32'(a);
    return PB'((x / W + x % W) % 16);
  endfunction

  // Memory model: latency 2, not reset, so a late response can follow a reset.
  logic          v1 = 1'b0;
  logic          v2 = 1'b0;
  logic [PB-1:0] d1 = '0;
  logic [PB-1:0] d2 = '0;
  always @(posedge tb_clk) begin
    v2 <= v1;
    d2 <= d1;
    v1 <= mem_read;
    d1 <= pix_of(mem_addr);
  end
  assign mem_valid = v2;
  assign mem_rdata = d2;

  // Monitor: reads tagged with the number of handoffs seen before them.
  rd_t         rd_q[$];
  win_t        win_q[$];
  int unsigned brdy_cnt = 0;
  int unsigned done_cnt = 0;
  always @(negedge tb_clk) begin
    if (mem_read) rd_q.push_back('{brdy_cnt, 32'(mem_addr)});
    if (bus_data_ready) begin
      win_q.push_back(input_pixels);
      brdy_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input win_t act, input win_t exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic win_t exp_win(input int unsigned r, input int unsigned c);
    win_t w;
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned j = 0; j < 4; j++)
        w[i][j] = PB'((r + i + c + j) % 16);
    return w;
  endfunction

  function automatic int unsigned exp_addr(input int unsigned r, input int unsigned c, input int unsigned n);
    if (c == 0) return (r + n / 4) * W + c + n % 4;
    return (r + n / 2) * W + c + 2 + n % 2;
  endfunction

  function automatic int unsigned count_tag(input int unsigned rb, input int unsigned tag);
    int unsigned n;
    n = 0;
    for (int unsigned q = rb; q < rd_q.size(); q++)
      if (rd_q[q].tag == tag) n++;
    return n;
  endfunction

  vec_t vecs[NWIN];

  task automatic check_pass(input int unsigned rb, input int unsigned bb, input int unsigned wb);
    int unsigned n;
    chk("window_count", win_q.size() - wb, NWIN);
    for (int unsigned k = 0; k < NWIN; k++) begin
      n = 0;
      for (int unsigned q = rb; q < rd_q.size(); q++) begin
        if (rd_q[q].tag == bb + k) begin
          if (n == 0) chk($sformatf("w%0d_first_addr", k), rd_q[q].addr, vecs[k].first);
          if (n + 1 == vecs[k].nrd) chk($sformatf("w%0d_last_addr", k), rd_q[q].addr, vecs[k].last);
          chk($sformatf("w%0d_addr%0d", k, n), rd_q[q].addr, exp_addr(vecs[k].r, vecs[k].c, n));
          n++;
        end
      end
      chk($sformatf("w%0d_nreads", k), n, vecs[k].nrd);
      if (wb + k < win_q.size()) begin
        chk_win($sformatf("w%0d_pixels", k), win_q[wb + k], exp_win(vecs[k].r, vecs[k].c));
        chk($sformatf("w%0d_p00", k), 32'(win_q[wb + k][0][0]), vecs[k].r + vecs[k].c);
        if (k > 0 && vecs[k].c > 0 && wb + k - 1 < win_q.size())
          for (int unsigned i = 0; i < 4; i++)
            chk($sformatf("w%0d_overlap_row%0d", k, i),
                32'({win_q[wb + k][i][1], win_q[wb + k][i][0]}),
                32'({win_q[wb + k - 1][i][3], win_q[wb + k - 1][i][2]}));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_data_ready"}, 32'(bus_data_ready), 0);
    chk({tag, "_mem_read"}, 32'(mem_read), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk_win({tag, "_input_pixels"}, input_pixels, '0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge tb_clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned db, input string tag);
    int unsigned n;
    n = 0;
    while (done_cnt == db && n < 3000) begin
      @(posedge tb_clk); #2;
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != db), 1);
  endtask

  initial begin
    int unsigned rb, bb, wb, db, n, glitch, unstable, rs;
    win_t snap;

    vecs[0] = '{0, 0, 16,  0, 27};
    vecs[1] = '{0, 2,  8,  4, 29};
    vecs[2] = '{0, 4,  8,  6, 31};
    vecs[3] = '{2, 0, 16, 16, 43};
    vecs[4] = '{2, 2,  8, 20, 45};
    vecs[5] = '{2, 4,  8, 22, 47};

    rst = 1'b1; start = 1'b0; need_data = 1'b0;
    repeat (3) @(posedge tb_clk);
    #2;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge tb_clk); #2;

    // Pass 1: stall after the first window, stray start while busy.
    rb = rd_q.size(); bb = brdy_cnt; wb = win_q.size(); db = done_cnt;
    need_data = 1'b1;
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    n = 0;
    while (!bus_data_ready && n < 300) begin
      @(posedge tb_clk); #2;
      n++;
    end
    chk("first_handoff_seen", 32'(bus_data_ready), 1);
    need_data = 1'b0;
    snap = input_pixels;
    glitch = 0; unstable = 0;
    for (int unsigned t = 0; t < 50; t++) begin
      @(posedge tb_clk); #2;
      if (t == 10) start = 1'b1;
      if (t == 11) start = 1'b0;
      if (bus_data_ready) glitch++;
      if (input_pixels != snap) unstable++;
    end
    chk("stall_no_pulse", glitch, 0);
    chk("stall_pixels_stable", unstable, 0);
    chk("stall_prefetch_reads", count_tag(rb, bb + 1), 8);
    chk("stall_busy", 32'(busy), 1);
    need_data = 1'b1;
    wait_done(db, "pass1");
    @(posedge tb_clk); #2;
    chk("pass1_busy_low", 32'(busy), 0);
    repeat (20) @(posedge tb_clk);
    #2;
    chk("pass1_done_pulses", done_cnt - db, 1);
    chk("pass1_handoffs", brdy_cnt - bb, NWIN);
    chk("pass1_total_reads", rd_q.size() - rb, 64);
    check_pass(rb, bb, wb);

    // Pass 2: repeat start reproduces the identical sequence.
    rb = rd_q.size(); bb = brdy_cnt; wb = win_q.size(); db = done_cnt;
    pulse_start();
    wait_done(db, "pass2");
    repeat (20) @(posedge tb_clk);
    #2;
    chk("pass2_done_pulses", done_cnt - db, 1);
    chk("pass2_handoffs", brdy_cnt - bb, NWIN);
    chk("pass2_busy_low", 32'(busy), 0);
    check_pass(rb, bb, wb);

    // Pass 3: reset mid-fetch.
    rb = rd_q.size(); bb = brdy_cnt; db = done_cnt;
    pulse_start();
    n = 0;
    while (rd_q.size() - rb < 5 && n < 300) begin
      @(posedge tb_clk); #2;
      n++;
    end
    chk("midrun_reads_started", 32'(rd_q.size() - rb >= 5), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrun_reset");
    rs = rd_q.size();
    repeat (3) @(posedge tb_clk);
    #2;
    rst = 1'b0;
    repeat (30) @(posedge tb_clk);
    #2;
    chk("post_reset_reads", rd_q.size() - rs, 0);
    chk("post_reset_handoffs", brdy_cnt - bb, 0);
    chk("post_reset_done", done_cnt - db, 0);
    chk("post_reset_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
